// File: rtl/debounced_edge_detector_pkg.sv
// -----------------------------------------------------------------------------
// debounced_edge_detector_pkg
//   Shared types for the debounced edge detector.
//   - state_t      : filter FSM state encoding
//   - stable_state : maps a level to its settled (STABLE_*) state
// -----------------------------------------------------------------------------
package debounced_edge_detector_pkg;

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'd0,
    CHECK_HIGH  = 2'd1,
    STABLE_HIGH = 2'd2,
    CHECK_LOW   = 2'd3
  } state_t;

  // Settled state that corresponds to a given filtered level.
  function automatic state_t stable_state(input logic level);
    state_t result;
    if (level) begin
      result = STABLE_HIGH;
    end else begin
      result = STABLE_LOW;
    end
    return result;
  endfunction

endpackage

// File: rtl/debounced_edge_detector_event_buffer.sv
// -----------------------------------------------------------------------------
// edge_event_buffer
//   One-entry valid/ready holding register. A push is accepted when the entry
//   is empty or is being popped in the same cycle; otherwise the pushed item
//   is dropped, the held item is left untouched and a sticky overflow flag is
//   raised.
// Ports
//   i_clock          clock, all state on rising edge
//   i_reset          synchronous active-high reset
//   i_push           new item offered this cycle
//   i_push_data      item payload
//   i_ready          consumer takes the entry when o_valid & i_ready
//   i_clear_overflow clears o_overflow (a simultaneous drop wins)
//   o_valid          entry holds an item
//   o_data           held item, stable while o_valid & !i_ready
//   o_overflow       sticky: an item was dropped because the entry was full
// -----------------------------------------------------------------------------
module edge_event_buffer #(
  parameter int DATA_W = 1
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_push_data,
  input  logic              i_ready,
  input  logic              i_clear_overflow,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic              o_overflow
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic              r_overflow;

  logic w_pop;
  logic w_accept;
  logic w_drop;

  // Handshake decode: a pop frees the entry for a push in the same cycle.
  always_comb begin
    w_pop    = r_valid & i_ready;
    w_accept = i_push & (~r_valid | w_pop);
    w_drop   = i_push & r_valid & ~i_ready;
  end

  // Entry storage and sticky overflow flag.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_valid    <= 1'b0;
      r_data     <= {DATA_W{1'b0}};
      r_overflow <= 1'b0;
    end else begin
      if (w_accept) begin
        r_valid <= 1'b1;
        r_data  <= i_push_data;
      end else if (w_pop) begin
        r_valid <= 1'b0;
      end else begin
        r_valid <= r_valid;
      end

      // A drop in the same cycle as a clear keeps the flag set.
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (i_clear_overflow) begin
        r_overflow <= 1'b0;
      end else begin
        r_overflow <= r_overflow;
      end
    end
  end

  assign o_valid    = r_valid;
  assign o_data     = r_data;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/debounced_edge_detector.sv
// -----------------------------------------------------------------------------
// debounced_edge_detector
//   Filters an already-synchronized level: a new level must be sampled on
//   STABLE_CYCLES consecutive clock edges before it is accepted. Presents the
//   filtered level, 1-cycle rising/falling strobes, and queues every filtered
//   edge as an event on a one-entry valid/ready interface.
// Parameters
//   STABLE_CYCLES  consecutive samples required to accept a new level (>=1)
//   RESET_VALUE    filtered level (and assumed input level) after reset
// Ports
//   clock           clock, all logic on rising edge
//   reset           synchronous active-high reset
//   data_in         synchronized input level
//   data_out        debounced level
//   rising_edge     strobe, high the cycle data_out first reads 1
//   falling_edge    strobe, high the cycle data_out first reads 0
//   event_valid     edge event pending
//   event_ready     consumer accepts event when valid & ready
//   event_polarity  1 = rising event, 0 = falling event
//   overflow        sticky: an edge was lost because the buffer was full
//   clear_overflow  clears overflow
// -----------------------------------------------------------------------------
module debounced_edge_detector
  import debounced_edge_detector_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter bit RESET_VALUE   = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic data_in,
  output logic data_out,
  output logic rising_edge,
  output logic falling_edge,
  output logic event_valid,
  input  logic event_ready,
  output logic event_polarity,
  output logic overflow,
  input  logic clear_overflow
);

  localparam int                CNT_W    = $clog2(STABLE_CYCLES + 1);
  // Count value at which the next matching sample completes the check.
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
  // With a single required sample the new level is accepted straight from
  // the STABLE state and the CHECK states are never used.
  localparam logic              SINGLE   = (STABLE_CYCLES == 1) ? 1'b1 : 1'b0;

  state_t           r_state;
  logic [CNT_W-1:0] r_count;
  logic             r_data_out;
  logic             r_rising;
  logic             r_falling;

  logic w_rise;
  logic w_fall;
  logic w_push;

  // Decide whether this clock edge completes a filtered transition.
  always_comb begin
    w_rise = 1'b0;
    w_fall = 1'b0;
    case (r_state)
      STABLE_LOW:  w_rise = data_in & SINGLE;
      CHECK_HIGH:  w_rise = data_in & (r_count == LAST_CNT);
      STABLE_HIGH: w_fall = ~data_in & SINGLE;
      CHECK_LOW:   w_fall = ~data_in & (r_count == LAST_CNT);
      default: begin
        w_rise = 1'b0;
        w_fall = 1'b0;
      end
    endcase
    w_push = w_rise | w_fall;
  end

  // Filter FSM, stability counter, filtered level and edge strobes.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= stable_state(RESET_VALUE);
      r_count    <= CNT_ZERO;
      r_data_out <= RESET_VALUE;
      r_rising   <= 1'b0;
      r_falling  <= 1'b0;
    end else begin
      r_rising  <= w_rise;
      r_falling <= w_fall;
      case (r_state)
        STABLE_LOW: begin
          if (w_rise) begin
            r_state    <= STABLE_HIGH;
            r_count    <= CNT_ZERO;
            r_data_out <= 1'b1;
          end else if (data_in) begin
            r_state <= CHECK_HIGH;
            r_count <= CNT_ONE;
          end else begin
            r_count <= CNT_ZERO;
          end
        end
        CHECK_HIGH: begin
          if (w_rise) begin
            r_state    <= STABLE_HIGH;
            r_count    <= CNT_ZERO;
            r_data_out <= 1'b1;
          end else if (data_in) begin
            r_count <= r_count + CNT_ONE;
          end else begin
            // Pulse too short: abandon without strobe or event.
            r_state <= STABLE_LOW;
            r_count <= CNT_ZERO;
          end
        end
        STABLE_HIGH: begin
          if (w_fall) begin
            r_state    <= STABLE_LOW;
            r_count    <= CNT_ZERO;
            r_data_out <= 1'b0;
          end else if (!data_in) begin
            r_state <= CHECK_LOW;
            r_count <= CNT_ONE;
          end else begin
            r_count <= CNT_ZERO;
          end
        end
        CHECK_LOW: begin
          if (w_fall) begin
            r_state    <= STABLE_LOW;
            r_count    <= CNT_ZERO;
            r_data_out <= 1'b0;
          end else if (!data_in) begin
            r_count <= r_count + CNT_ONE;
          end else begin
            r_state <= STABLE_HIGH;
            r_count <= CNT_ZERO;
          end
        end
        default: begin
          r_state <= stable_state(r_data_out);
          r_count <= CNT_ZERO;
        end
      endcase
    end
  end

  // Every filtered edge is offered to the event buffer in the same cycle the
  // strobe register loads, so the event appears together with the strobe.
  edge_event_buffer #(
    .DATA_W (1)
  ) u_event_buffer (
    .i_clock          (clock),
    .i_reset          (reset),
    .i_push           (w_push),
    .i_push_data      (w_rise),
    .i_ready          (event_ready),
    .i_clear_overflow (clear_overflow),
    .o_valid          (event_valid),
    .o_data           (event_polarity),
    .o_overflow       (overflow)
  );

  assign data_out     = r_data_out;
  assign rising_edge  = r_rising;
  assign falling_edge = r_falling;

endmodule

// File: tb/tb_debounced_edge_detector.sv
module tb_debounced_edge_detector;

  localparam logic lo = 1'b0;
  localparam logic hi = 1'b1;

  logic clock = 1'b0;
  logic reset;

  // STABLE_CYCLES = 4 instance
  logic data_in, event_ready, clear_overflow;
  logic data_out, rising_edge, falling_edge, event_valid, event_polarity, overflow;

  // STABLE_CYCLES = 1 instance
  logic d1_in, d1_ready, d1_clr;
  logic d1_out, d1_rise, d1_fall, d1_valid, d1_pol, d1_ovf;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic rst, din, rdy, clr;
    logic out, rise, fall, vld, pol, ovf;
  } vec_t;

  vec_t vecs[$];

  always #5 clock = ~clock;

  debounced_edge_detector #(.STABLE_CYCLES(4), .RESET_VALUE(1'b0)) dut4 (
    .clock          (clock),
    .reset          (reset),
    .data_in        (data_in),
    .data_out       (data_out),
    .rising_edge    (rising_edge),
    .falling_edge   (falling_edge),
    .event_valid    (event_valid),
    .event_ready    (event_ready),
    .event_polarity (event_polarity),
    .overflow       (overflow),
    .clear_overflow (clear_overflow)
  );

  debounced_edge_detector #(.STABLE_CYCLES(1), .RESET_VALUE(1'b0)) dut1 (
    .clock          (clock),
    .reset          (reset),
    .data_in        (d1_in),
    .data_out       (d1_out),
    .rising_edge    (d1_rise),
    .falling_edge   (d1_fall),
    .event_valid    (d1_valid),
    .event_ready    (d1_ready),
    .event_polarity (d1_pol),
    .overflow       (d1_ovf),
    .clear_overflow (d1_clr)
  );

  task automatic add(input logic rst, input logic din, input logic rdy, input logic clr,
                     input logic out, input logic rise, input logic fall,
                     input logic vld, input logic pol, input logic ovf);
    vec_t v;
    v.rst = rst; v.din = din; v.rdy = rdy; v.clr = clr;
    v.out = out; v.rise = rise; v.fall = fall; v.vld = vld; v.pol = pol; v.ovf = ovf;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0b expected %0b", name, idx, act, exp);
    end
  endtask

  logic [15:0] pat;
  logic        m_out, m_rise, m_fall, m_vld, m_pol;

  initial begin
    reset = hi; data_in = lo; event_ready = lo; clear_overflow = lo;
    d1_in = lo; d1_ready = hi; d1_clr = lo;

    // Reset, then quiet input
    repeat (2) add(hi, lo, lo, lo,  lo, lo, lo, lo, lo, lo);
    repeat (20) add(lo, lo, lo, lo,  lo, lo, lo, lo, lo, lo);
    // 3-cycle high pulse is rejected
    repeat (3) add(lo, hi, lo, lo,  lo, lo, lo, lo, lo, lo);
    repeat (2) add(lo, lo, lo, lo,  lo, lo, lo, lo, lo, lo);
    // Held high: accepted on the 4th sampling edge
    repeat (3) add(lo, hi, lo, lo,  lo, lo, lo, lo, lo, lo);
    add(lo, hi, lo, lo,  hi, hi, lo, hi, hi, lo);
    add(lo, hi, lo, lo,  hi, lo, lo, hi, hi, lo);
    // 3-cycle low glitch while high is rejected
    repeat (3) add(lo, lo, lo, lo,  hi, lo, lo, hi, hi, lo);
    add(lo, hi, lo, lo,  hi, lo, lo, hi, hi, lo);
    // Fall while rising event is held: dropped, overflow set beats clear
    repeat (3) add(lo, lo, lo, lo,  hi, lo, lo, hi, hi, lo);
    add(lo, lo, lo, hi,  lo, lo, hi, hi, hi, hi);
    add(lo, lo, lo, lo,  lo, lo, lo, hi, hi, hi);
    add(lo, lo, lo, hi,  lo, lo, lo, hi, hi, lo);
    // Pop with no new edge empties the buffer
    add(lo, lo, hi, lo,  lo, lo, lo, lo, hi, lo);
    // New rise held, then pop coinciding with a fall edge
    repeat (3) add(lo, hi, lo, lo,  lo, lo, lo, lo, hi, lo);
    add(lo, hi, lo, lo,  hi, hi, lo, hi, hi, lo);
    repeat (3) add(lo, lo, lo, lo,  hi, lo, lo, hi, hi, lo);
    add(lo, lo, hi, lo,  lo, lo, hi, hi, lo, lo);
    add(lo, lo, hi, lo,  lo, lo, lo, lo, lo, lo);
    // Reset after two high samples abandons the check; a full check follows
    repeat (2) add(lo, hi, lo, lo,  lo, lo, lo, lo, lo, lo);
    add(hi, hi, lo, lo,  lo, lo, lo, lo, lo, lo);
    repeat (3) add(lo, hi, lo, lo,  lo, lo, lo, lo, lo, lo);
    add(lo, hi, lo, lo,  hi, hi, lo, hi, hi, lo);
    // Reset with an event pending and data_out high
    add(hi, hi, lo, lo,  lo, lo, lo, lo, lo, lo);
    add(lo, lo, lo, lo,  lo, lo, lo, lo, lo, lo);

    for (int i = 0; i < vecs.size(); i++) begin
      reset          = vecs[i].rst;
      data_in        = vecs[i].din;
      event_ready    = vecs[i].rdy;
      clear_overflow = vecs[i].clr;
      @(posedge clock);
      #1;
      check("data_out",       i, data_out,       vecs[i].out);
      check("rising_edge",    i, rising_edge,    vecs[i].rise);
      check("falling_edge",   i, falling_edge,   vecs[i].fall);
      check("event_valid",    i, event_valid,    vecs[i].vld);
      check("event_polarity", i, event_polarity, vecs[i].pol);
      check("overflow",       i, overflow,       vecs[i].ovf);
    end

    // STABLE_CYCLES=1: data_out follows data_in one cycle later; with ready
    // always high, back-to-back edges pop and refill the buffer each cycle.
    reset = lo; data_in = lo; event_ready = lo; clear_overflow = lo;
    pat   = 16'b0110_1011_0010_1110;
    m_out = 1'b0;
    m_pol = 1'b0;
    for (int i = 0; i < 16; i++) begin
      d1_in = pat[15-i];
      @(posedge clock);
      #1;
      m_rise = d1_in & ~m_out;
      m_fall = ~d1_in & m_out;
      m_vld  = m_rise | m_fall;
      if (m_vld) m_pol = d1_in;
      m_out  = d1_in;
      check("sc1_data_out",       i, d1_out,   m_out);
      check("sc1_rising_edge",    i, d1_rise,  m_rise);
      check("sc1_falling_edge",   i, d1_fall,  m_fall);
      check("sc1_event_valid",    i, d1_valid, m_vld);
      check("sc1_event_polarity", i, d1_pol,   m_pol);
      check("sc1_overflow",       i, d1_ovf,   1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
